// File: rtl/dfe_rnd_pkg.sv
// Shared constants for the DFE round/saturate stage: rounding-mode encodings and
// the fixed input-to-output latency.
package dfe_rnd_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'd0;
    localparam logic [1:0] RND_HALF_UP   = 2'd1;
    localparam logic [1:0] RND_HALF_EVEN = 2'd2;

    localparam int unsigned RND_SATU_LAT = 3;

endpackage

// File: rtl/data_rnd_satu_lane.sv
// One channel of the round/saturate pipeline: registered rounding stage followed by a
// registered saturation stage with clamp flag.
module data_rnd_satu_lane
    import dfe_rnd_pkg::*;
#(
    parameter int DIN_WIDTH  = 33,
    parameter int FRAC_WIDTH = 16,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rnd_en,
    input  logic                  sat_en,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic [1:0]            mode,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat
);

    // One extra MSB so a round-up carry can never wrap.
    localparam int RW = DIN_WIDTH - FRAC_WIDTH + 1;

    logic [RW-1:0]         rnd_d, rnd_q;
    logic [DOUT_WIDTH-1:0] sat_data, dout_q;
    logic                  sat_hit, sat_q;

    generate
        if (FRAC_WIDTH == 0) begin : g_bypass
            logic unused_mode;
            assign unused_mode = ^mode;
            assign rnd_d = {din[DIN_WIDTH-1], din};
        end else begin : g_round
            localparam int EW = DIN_WIDTH + 1;
            localparam logic [EW-1:0] HALF = EW'(1) << (FRAC_WIDTH - 1);
            logic [EW-1:0] ext, bias, sum;
            logic          unused_low;

            always_comb begin
                ext = {din[DIN_WIDTH-1], din};
                case (mode)
                    RND_TRUNC:     bias = '0;
                    RND_HALF_EVEN: bias = HALF - EW'(1) + EW'(din[FRAC_WIDTH]);
                    default:       bias = HALF;
                endcase
                sum = ext + bias;
            end

            assign rnd_d      = sum[EW-1:FRAC_WIDTH];
            assign unused_low = ^sum[FRAC_WIDTH-1:0];
        end
    endgenerate

    generate
        if (RW > DOUT_WIDTH) begin : g_clamp
            logic [RW-DOUT_WIDTH:0] top;
            assign top = rnd_q[RW-1:DOUT_WIDTH-1];

            // In range only when every bit above the output sign matches it.
            always_comb begin
                sat_hit  = !((&top) || !(|top));
                sat_data = rnd_q[DOUT_WIDTH-1:0];
                if (sat_hit) begin
                    sat_data = rnd_q[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_extend
            assign sat_data = DOUT_WIDTH'($signed(rnd_q));
            assign sat_hit  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q  <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (rnd_en) begin
                rnd_q <= rnd_d;
            end
            if (sat_en) begin
                dout_q <= sat_data;
                sat_q  <= sat_hit;
            end
        end
    end

    assign dout = dout_q;
    assign sat  = sat_q;

endmodule

// File: rtl/data_rnd_satu_mc.sv
// Multi-channel round/saturate stage with shared valid and per-channel clamp flags.
// Saturation counters are built only when DATA_RND_SATU_CNT_EN is defined.
module data_rnd_satu_mc
    import dfe_rnd_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DIN_WIDTH  = 33,
    parameter int FRAC_WIDTH = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [NCH*DIN_WIDTH-1:0]  i_data,
    input  logic [1:0]                i_rnd_mode,
    input  logic                      i_cnt_clr,
    output logic                      o_valid,
    output logic [NCH*DOUT_WIDTH-1:0] o_data,
    output logic [NCH-1:0]            o_sat_flag,
    output logic [NCH*CNT_WIDTH-1:0]  o_sat_cnt
);

    logic [NCH*DIN_WIDTH-1:0] data_q;
    logic [1:0]               mode_q;
    logic [RND_SATU_LAT-1:0]  vld_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
            mode_q <= RND_TRUNC;
            vld_q  <= '0;
        end else begin
            vld_q <= {vld_q[RND_SATU_LAT-2:0], i_valid};
            if (i_valid) begin
                data_q <= i_data;
                mode_q <= i_rnd_mode;
            end
        end
    end

    assign o_valid = vld_q[RND_SATU_LAT-1];

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        data_rnd_satu_lane #(
            .DIN_WIDTH  (DIN_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH),
            .DOUT_WIDTH (DOUT_WIDTH)
        ) u_lane (
            .clk    (i_clk),
            .rst    (i_rst),
            .rnd_en (vld_q[0]),
            .sat_en (vld_q[1]),
            .din    (data_q[k*DIN_WIDTH +: DIN_WIDTH]),
            .mode   (mode_q),
            .dout   (o_data[k*DOUT_WIDTH +: DOUT_WIDTH]),
            .sat    (o_sat_flag[k])
        );
    end

`ifdef DATA_RND_SATU_CNT_EN
    logic [NCH*CNT_WIDTH-1:0] cnt_q;
    logic [NCH-1:0]           cnt_inc;

    assign cnt_inc = {NCH{o_valid}} & o_sat_flag;

    // A clear coinciding with an event restarts at 1 so that event is kept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (i_cnt_clr) begin
                    cnt_q[k*CNT_WIDTH +: CNT_WIDTH] <= CNT_WIDTH'(cnt_inc[k]);
                end else if (cnt_inc[k] && (cnt_q[k*CNT_WIDTH +: CNT_WIDTH] != '1)) begin
                    cnt_q[k*CNT_WIDTH +: CNT_WIDTH] <=
                        cnt_q[k*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign o_sat_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = i_cnt_clr;
    assign o_sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_data_rnd_satu_mc.sv
// Bench for data_rnd_satu_mc: table-driven vectors with a latency-stamped scoreboard,
// plus hand-written rounding-carry, counter and reset sequences.
module tb_data_rnd_satu_mc;
    import dfe_rnd_pkg::*;

    localparam int NCH  = 2;
    localparam int DIN  = 18;
    localparam int FRAC = 4;
    localparam int DOUT = 12;
    localparam int CW   = 4;
`ifdef DATA_RND_SATU_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk, rst, valid, clr, o_valid;
    logic [NCH*DIN-1:0]   data;
    logic [1:0]           mode;
    logic [NCH*DOUT-1:0]  o_data;
    logic [NCH-1:0]       o_flag;
    logic [NCH*CW-1:0]    o_cnt;

    logic       b_valid, b_ovalid;
    logic [7:0] b_data;
    logic [1:0] b_mode;
    logic [3:0] b_odata, b_cnt;
    logic [0:0] b_flag;

    data_rnd_satu_mc #(
        .NCH(NCH), .DIN_WIDTH(DIN), .FRAC_WIDTH(FRAC), .DOUT_WIDTH(DOUT), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_rnd_mode(mode),
        .i_cnt_clr(clr), .o_valid(o_valid), .o_data(o_data), .o_sat_flag(o_flag),
        .o_sat_cnt(o_cnt)
    );

    data_rnd_satu_mc #(
        .NCH(1), .DIN_WIDTH(8), .FRAC_WIDTH(4), .DOUT_WIDTH(4), .CNT_WIDTH(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_data(b_data), .i_rnd_mode(b_mode),
        .i_cnt_clr(1'b0), .o_valid(b_ovalid), .o_data(b_odata), .o_sat_flag(b_flag),
        .o_sat_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         d0;
        int         d1;
        int         e0;
        int         e1;
        logic [1:0] flag;
    } vec_t;

    typedef struct {
        int                  due;
        logic [NCH*DOUT-1:0] data;
        logic [1:0]          flag;
    } exp_t;

    typedef struct {
        int         due;
        logic [3:0] data;
        logic       flag;
    } bexp_t;

    vec_t  vecs[14];
    exp_t  sb[$];
    bexp_t sbb[$];

    int                  n_checks, n_fails, cyc;
    logic [NCH*DOUT-1:0] last_data;
    logic [1:0]          last_flag;
    logic [3:0]          b_last_data;
    logic                b_last_flag;
    logic [CW-1:0]       exp_cnt[NCH];

    function automatic logic [NCH*DOUT-1:0] pk(input int a, input int b);
        return {DOUT'(b), DOUT'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic monitor();
        exp_t       e;
        bexp_t      eb;
        logic [1:0] inc;
        @(negedge clk);
        inc = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("o_valid", 32'(o_valid), 32'd1);
            chk("o_data", 32'(o_data), 32'(e.data));
            chk("o_sat_flag", 32'(o_flag), 32'(e.flag));
            last_data = e.data;
            last_flag = e.flag;
            inc       = e.flag;
        end else begin
            chk("o_valid_idle", 32'(o_valid), 32'd0);
            chk("o_data_hold", 32'(o_data), 32'(last_data));
            chk("o_sat_flag_hold", 32'(o_flag), 32'(last_flag));
        end
        chk("o_sat_cnt", 32'(o_cnt), 32'({exp_cnt[1], exp_cnt[0]}));
        if (CNT_EN) begin
            for (int k = 0; k < NCH; k++) begin
                if (clr) exp_cnt[k] = CW'(inc[k]);
                else if (inc[k] && exp_cnt[k] != '1) exp_cnt[k] = exp_cnt[k] + 1'b1;
            end
        end
        if (sbb.size() > 0 && sbb[0].due == cyc) begin
            eb = sbb.pop_front();
            chk("b_o_valid", 32'(b_ovalid), 32'd1);
            chk("b_o_data", 32'(b_odata), 32'(eb.data));
            chk("b_o_sat_flag", 32'(b_flag), 32'(eb.flag));
            b_last_data = eb.data;
            b_last_flag = eb.flag;
        end else begin
            chk("b_o_valid_idle", 32'(b_ovalid), 32'd0);
            chk("b_o_data_hold", 32'(b_odata), 32'(b_last_data));
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input int d0, input int d1,
                         input logic [NCH*DOUT-1:0] ed, input logic [1:0] ef, input bit c);
        valid = v;
        mode  = m;
        data  = {DIN'(d1), DIN'(d0)};
        clr   = c;
        if (v) sb.push_back('{due: cyc + 3, data: ed, flag: ef});
        monitor();
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, RND_TRUNC, 0, 0, '0, '0, 1'b0);
    endtask

    task automatic drive_b(input logic [1:0] m, input logic [7:0] d, input logic [3:0] ed,
                           input logic ef);
        b_valid = 1'b1;
        b_mode  = m;
        b_data  = d;
        sbb.push_back('{due: cyc + 3, data: ed, flag: ef});
        idle(1);
        b_valid = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        sbb.delete();
        last_data   = '0;
        last_flag   = '0;
        b_last_data = '0;
        b_last_flag = 1'b0;
        for (int k = 0; k < NCH; k++) exp_cnt[k] = '0;
    endtask

    initial begin
        vecs[0]  = '{RND_TRUNC,     53,     -53,     3,     -4,    2'b00};
        vecs[1]  = '{RND_HALF_UP,   40,     -40,     3,     -2,    2'b00};
        vecs[2]  = '{RND_HALF_EVEN, 40,     56,      2,     4,     2'b00};
        vecs[3]  = '{RND_HALF_EVEN, -40,    24,      -2,    2,     2'b00};
        vecs[4]  = '{2'd3,          40,     -40,     3,     -2,    2'b00};
        vecs[5]  = '{RND_TRUNC,     131071, 0,       2047,  0,     2'b01};
        vecs[6]  = '{RND_TRUNC,     0,      -131072, 0,     -2048, 2'b10};
        vecs[7]  = '{RND_TRUNC,     32767,  32768,   2047,  2047,  2'b10};
        vecs[8]  = '{RND_HALF_UP,   32760,  -32768,  2047,  -2048, 2'b01};
        vecs[9]  = '{RND_TRUNC,     -32769, -32768,  -2048, -2048, 2'b01};
        vecs[10] = '{RND_HALF_EVEN, 8,      24,      0,     2,     2'b00};
        vecs[11] = '{RND_TRUNC,     -1,     15,      -1,    0,     2'b00};
        vecs[12] = '{RND_HALF_UP,   -8,     -9,      0,     -1,    2'b00};
        vecs[13] = '{RND_HALF_UP,   131071, -131072, 2047,  -2048, 2'b11};

        n_checks = 0;
        n_fails  = 0;
        cyc      = 0;
        rst      = 1'b1;
        valid    = 1'b0;
        data     = '0;
        mode     = RND_TRUNC;
        clr      = 1'b0;
        b_valid  = 1'b0;
        b_data   = '0;
        b_mode   = RND_TRUNC;
        model_reset();

        #12;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_sat_flag", 32'(o_flag), 32'd0);
        chk("rst_o_sat_cnt", 32'(o_cnt), 32'd0);
        tick();
        rst = 1'b0;
        idle(2);

        // Back-to-back table, mode changing per sample.
        for (int i = 0; i < 14; i++)
            drive(1'b1, vecs[i].mode, vecs[i].d0, vecs[i].d1, pk(vecs[i].e0, vecs[i].e1),
                  vecs[i].flag, 1'b0);
        idle(4);

        // Rounding carry into the extra MSB on the narrow instance.
        drive_b(RND_HALF_UP,   8'd127,  4'd7, 1'b1);
        drive_b(RND_TRUNC,     8'd127,  4'd7, 1'b0);
        drive_b(RND_HALF_EVEN, 8'd127,  4'd7, 1'b1);
        drive_b(RND_TRUNC,     8'h80,   4'h8, 1'b0);
        idle(4);
        chk("b_cnt", 32'(b_cnt), CNT_EN ? 32'd2 : 32'd0);

        // Counter saturation: clear, then 20 clamped samples on ch0 only.
        drive(1'b0, RND_TRUNC, 0, 0, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++)
            drive(1'b1, RND_TRUNC, 131071, 0, pk(2047, 0), 2'b01, 1'b0);
        idle(4);
        chk("cnt_held", 32'(o_cnt), CNT_EN ? 32'h0F : 32'd0);

        // Clear in the same cycle as a counted event.
        drive(1'b1, RND_TRUNC, 131071, 0, pk(2047, 0), 2'b01, 1'b0);
        idle(2);
        drive(1'b0, RND_TRUNC, 0, 0, '0, '0, 1'b1);
        idle(1);
        chk("cnt_clr_coincident", 32'(o_cnt), CNT_EN ? 32'h01 : 32'd0);
        drive(1'b0, RND_TRUNC, 0, 0, '0, '0, 1'b1);
        idle(1);
        chk("cnt_clr_alone", 32'(o_cnt), 32'd0);

        // Reset with samples in flight.
        for (int i = 0; i < 3; i++)
            drive(1'b1, RND_TRUNC, 131071, -53, pk(2047, -4), 2'b01, 1'b0);
        idle(1);
        rst = 1'b1;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_data", 32'(o_data), 32'd0);
        chk("midrst_o_sat_flag", 32'(o_flag), 32'd0);
        chk("midrst_o_sat_cnt", 32'(o_cnt), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        idle(5);
        drive(1'b1, RND_HALF_UP, 40, -40, pk(3, -2), 2'b00, 1'b0);
        idle(4);
        chk("scoreboard_drained", 32'(sb.size() + sbb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/data_rnd_satu_mc.md
# data_rnd_satu_mc

Multi-channel, handshaked successor to the single-channel DFE round/saturate stage. It takes NCH packed fixed-point samples and drops FRAC_WIDTH fraction bits using a runtime-selectable rounding mode. It then saturates each result to DOUT_WIDTH and reports per-channel saturation flags and event counters. It sits at the output of the DFE filter/gain chain, ahead of DAC/JESD formatting.

## Interface
- NCH, 4: number of parallel channels
- DIN_WIDTH, 33: signed input width per channel
- FRAC_WIDTH, 16: fraction bits removed, 0..DIN_WIDTH-2; 0 means rounding is bypassed
- DOUT_WIDTH, 16: signed output width per channel, ≥2
- CNT_WIDTH, 16: width of each saturation counter
- i_clk  in  1  sole clock
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input sample strobe; all channels share it
- i_data  in  NCH*DIN_WIDTH  channel k occupies [k*DIN_WIDTH +: DIN_WIDTH], two's complement
- i_rnd_mode  in  2  0 truncate (floor), 1 round half up, 2 round half to even, 3 same as 1
- i_cnt_clr  in  1  single-cycle pulse that clears all saturation counters
- o_valid  out  1  output sample strobe
- o_data  out  NCH*DOUT_WIDTH  rounded and saturated samples, same packing as i_data
- o_sat_flag  out  NCH  bit k set when channel k of the current o_data sample was clamped
- o_sat_cnt  out  NCH*CNT_WIDTH  per-channel saturated-sample counters

## Operation
- Stage 1 registers i_data, i_valid and i_rnd_mode together. The mode is captured per sample, so a mode change affects only samples registered after it.
- Stage 2 rounds each channel to R = DIN_WIDTH-FRAC_WIDTH+1 bits. The extra MSB absorbs the carry from rounding up, so rounding never wraps.
  - Truncate: arithmetic shift right by FRAC_WIDTH.
  - Half up: add 2^(FRAC_WIDTH-1), then shift.
  - Half even: add 2^(FRAC_WIDTH-1)-1+LSB_kept, then shift.
  - FRAC_WIDTH=0: data is sign-extended to R bits in every mode.
- Stage 3 saturates to DOUT_WIDTH.
  - If R > DOUT_WIDTH, clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] and set the flag when clamping occurs.
  - Otherwise sign-extend; the flag is never set.
- Each counter increments on o_valid samples whose flag bit is set. It holds at all-ones and never wraps.
- If i_cnt_clr arrives in the same cycle as an increment, the counter becomes 1, so no event is lost. i_cnt_clr alone sets it to 0.
- Pipeline registers without a valid sample keep their previous data. o_data, o_sat_flag and o_sat_cnt change only on o_valid cycles or on clear.

## Timing
- Latency is exactly 3 cycles: o_valid(t+3) = i_valid(t), and o_data and o_sat_flag are aligned with o_valid.
- Full throughput: one sample per cycle on every channel, with no backpressure.
- o_sat_cnt updates 1 cycle after the o_valid cycle that carried the flag. Clearing takes effect 1 cycle after i_cnt_clr.
- Reset value of every output and internal register is 0.
- Asserting i_rst mid-stream discards in-flight samples: o_valid drops to 0 asynchronously. After release, o_valid stays 0 until 3 cycles after the first new i_valid.

## Configuration
- DATA_RND_SATU_CNT_EN defined: counters and i_cnt_clr logic are built as described above.
- DATA_RND_SATU_CNT_EN undefined: o_sat_cnt is tied to 0 and i_cnt_clr is ignored. o_sat_flag and all other behaviour are unchanged.

## Structure
- Package dfe_rnd_pkg holds:
  - Rounding-mode constants: RND_TRUNC=2'd0, RND_HALF_UP=2'd1, RND_HALF_EVEN=2'd2.
  - The latency constant RND_SATU_LAT=3.
- Sub-module data_rnd_satu_lane handles one channel: stages 2–3 round/saturate plus flag output. The top instantiates it NCH times in a generate loop.
- Input registers, valid pipeline and counters live in the top level.

## Test plan
Unless a scenario says otherwise, use DIN=18, FRAC=4, DOUT=12, NCH=2, CNT_WIDTH=4.
- Truncate: input 53 → 3; input -53 → -4; flag 0; o_valid exactly 3 cycles after i_valid.
- Half up: 40 → 3, -40 → -2. Half even: 40 → 2, 56 → 4, -40 → -2. Switching mode between back-to-back samples applies per sample.
- Saturation: ch0 input 131071 → 2047 with flag bit 0 set; ch1 input -131072 → -2048 with flag bit 1 set; in-range samples return flag 0.
- Rounding carry with DIN=8, FRAC=4, DOUT=4: input 127 in half-up mode → 8 internally, output 7 with flag set; in truncate mode → 7 with flag 0.
- Counters: 20 saturated samples on ch0 → o_sat_cnt ch0=15 (held), ch1=0. i_cnt_clr coincident with a saturated sample → 1. With the macro undefined, o_sat_cnt stays 0.
- Reset: pulse i_rst with 2 samples in flight → o_valid and all outputs 0 at once, no stray o_valid after release, and the next sample has correct 3-cycle latency.
